// File: rtl/dmux8_sequencer.sv
// dmux8_sequencer
// Drives the select and data lines of a 1-to-8 demultiplexer. It visits the
// channels enabled in a mask in ascending order. For each visited channel it
// holds d0 high for ON_CYCLES clocks and then low for OFF_CYCLES clocks.
// It can run a single sweep or loop continuously, with a start/busy/done
// handshake and an abort input.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; select parked at 000, d0 low
// ST_ON    | d0 high on the current channel, counter counts ON phase
// ST_OFF   | d0 low on the current channel, counter counts OFF gap
module dmux8_sequencer #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       loop,
  input  logic [7:0] mask,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       d0,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       chan, chan_nx;
  logic [7:0]       mask_q, mask_nx;
  logic             loop_q, loop_nx;
  logic             d0_q, d0_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;

  logic [7:0]       above;
  logic             has_next;
  logic [2:0]       next_ch;
  logic [2:0]       first_new;
  logic [2:0]       first_latched;

  // Index of the lowest set bit; returns 0 for an empty mask, callers gate on that.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Channel search. 'above' keeps only the latched bits strictly higher than
  // the current channel; for channel 7 the shifted term is 0, so nothing is left.
  always_comb begin
    above         = mask_q & ~((8'd2 << chan) - 8'd1);
    has_next      = |above;
    next_ch       = lowest_bit(above);
    first_new     = lowest_bit(mask);
    first_latched = lowest_bit(mask_q);
  end

  // Next-state and next-output logic. Abort overrides all progress in ON/OFF.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    chan_nx  = chan;
    mask_nx  = mask_q;
    loop_nx  = loop_q;
    done_nx  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (mask != 8'h00) begin
            mask_nx  = mask;
            loop_nx  = loop;
            chan_nx  = first_new;
            cnt_nx   = '0;
            state_nx = ST_ON;
          end else begin
            done_nx = 1'b1;
          end
        end
      end

      ST_ON: begin
        if (abort) begin
          state_nx = ST_IDLE;
          chan_nx  = '0;
          cnt_nx   = '0;
        end else if (cnt == ON_LAST) begin
          state_nx = ST_OFF;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      ST_OFF: begin
        if (abort) begin
          state_nx = ST_IDLE;
          chan_nx  = '0;
          cnt_nx   = '0;
        end else if (cnt == OFF_LAST) begin
          cnt_nx = '0;
          if (has_next) begin
            chan_nx  = next_ch;
            state_nx = ST_ON;
          end else if (loop_q) begin
            chan_nx  = first_latched;
            state_nx = ST_ON;
          end else begin
            chan_nx  = '0;
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = ST_IDLE;
        chan_nx  = '0;
        cnt_nx   = '0;
      end
    endcase

    d0_nx   = (state_nx == ST_ON);
    busy_nx = (state_nx != ST_IDLE);
  end

  // State, counter, latched configuration and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      chan   <= '0;
      mask_q <= '0;
      loop_q <= 1'b0;
      d0_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      chan   <= chan_nx;
      mask_q <= mask_nx;
      loop_q <= loop_nx;
      d0_q   <= d0_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
    end
  end

  assign {s2, s1, s0} = chan;
  assign d0           = d0_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dmux8_sequencer.sv
// Testbench for dmux8_sequencer with ON_CYCLES=4 and OFF_CYCLES=2.
// It applies a table of directed vectors, then runs sweeps that are checked
// cycle by cycle against an expected trace built from the channel list.
module tb_dmux8_sequencer;

  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] mask = 8'h00;
  logic       s2, s1, s0, d0, busy, done;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs packed as {s[2:0], d0, busy, done}.
  logic [5:0] exp_q[$];

  dmux8_sequencer #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
    .mask(mask), .s2(s2), .s1(s1), .s0(s0), .d0(d0), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    bit         st;
    bit         ab;
    bit         lp;
    logic [7:0] m;
    logic [5:0] want;
    string      name;
  } vec_t;

  vec_t vt[$];

  function automatic logic [5:0] mk(input int ch, input bit dd, input bit bb, input bit dn);
    return {3'(ch), dd, bb, dn};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] want);
    logic [5:0] act;
    act = {s2, s1, s0, d0, busy, done};
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got s=%0d d0=%0b busy=%0b done=%0b, want s=%0d d0=%0b busy=%0b done=%0b",
               name, act[5:3], act[2], act[1], act[0], want[5:3], want[2], want[1], want[0]);
    end
  endtask

  // Expected trace from the sweep rules: the set bits ascending, each with
  // ON high cycles then OFF low cycles, repeated while looping, and a single
  // done cycle at the end of a non-looping sweep.
  task automatic build_trace(input logic [7:0] m, input bit lp, input int maxlen);
    int chans[$];
    exp_q.delete();
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    if (chans.size() == 0) begin
      exp_q.push_back(mk(0, 0, 0, 1));
      return;
    end
    do begin
      foreach (chans[k]) begin
        repeat (ON)  exp_q.push_back(mk(chans[k], 1, 1, 0));
        repeat (OFF) exp_q.push_back(mk(chans[k], 0, 1, 0));
      end
    end while (lp && exp_q.size() < maxlen);
    if (!lp) exp_q.push_back(mk(0, 0, 0, 1));
    while (exp_q.size() > maxlen) void'(exp_q.pop_back());
  endtask

  // Starts a sweep and compares every cycle. Spurious start pulses and
  // mask/loop changes are applied while busy. If abort_at > 0, abort is
  // asserted on the cycle before trace index abort_at.
  task automatic run_case(input string tag, input logic [7:0] m, input bit lp,
                          input int abort_at, input int maxlen);
    build_trace(m, lp, maxlen);
    start = 1'b1; mask = m; loop = lp; abort = 1'b0;
    tick;
    start = 1'b0; mask = 8'($urandom); loop = 1'($urandom);
    check($sformatf("%s[0]", tag), exp_q[0]);
    for (int i = 1; i < exp_q.size(); i++) begin
      start = ($urandom_range(0, 3) == 0);
      mask  = 8'($urandom);
      loop  = 1'($urandom);
      if (i == abort_at) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        check($sformatf("%s_abort@%0d", tag, i), 6'b0);
        break;
      end
      tick;
      check($sformatf("%s[%0d]", tag, i), exp_q[i]);
    end
    start = 1'b0; abort = 1'b0;
    repeat (2) begin
      tick;
      check($sformatf("%s_idle", tag), 6'b0);
    end
  endtask

  initial begin
    logic [7:0] rm;
    bit         rl;
    int         len, ab;

    // Directed vectors: reset, priorities, empty mask, abort in IDLE, and a one-channel sweep.
    vt.push_back('{1, 0, 0, 0, 8'h00, 6'b000000, "rst_a"});
    vt.push_back('{1, 1, 1, 0, 8'hFF, 6'b000000, "rst_over_abort_start"});
    vt.push_back('{1, 1, 0, 1, 8'hFF, 6'b000000, "rst_over_start"});
    vt.push_back('{0, 0, 0, 0, 8'hFF, 6'b000000, "idle_no_start_a"});
    vt.push_back('{0, 0, 0, 1, 8'h00, 6'b000000, "idle_no_start_b"});
    vt.push_back('{0, 1, 0, 0, 8'h00, 6'b000001, "mask0_done"});
    vt.push_back('{0, 0, 0, 0, 8'h00, 6'b000000, "mask0_done_clear"});
    vt.push_back('{0, 1, 1, 0, 8'hFF, 6'b000000, "abort_blocks_start"});
    vt.push_back('{0, 0, 0, 0, 8'hFF, 6'b000000, "abort_idle_after"});
    vt.push_back('{0, 1, 0, 0, 8'h04, 6'b010110, "ch2_on0"});
    vt.push_back('{0, 0, 0, 1, 8'hFF, 6'b010110, "ch2_on1"});
    vt.push_back('{0, 1, 0, 1, 8'hFF, 6'b010110, "ch2_on2"});
    vt.push_back('{0, 0, 0, 0, 8'h01, 6'b010110, "ch2_on3"});
    vt.push_back('{0, 0, 0, 0, 8'h01, 6'b010010, "ch2_off0"});
    vt.push_back('{0, 0, 0, 0, 8'h01, 6'b010010, "ch2_off1"});
    vt.push_back('{0, 0, 0, 0, 8'h00, 6'b000001, "ch2_done"});
    vt.push_back('{0, 0, 0, 0, 8'h00, 6'b000000, "ch2_after"});

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].r; start = vt[i].st; abort = vt[i].ab;
      loop = vt[i].lp; mask = vt[i].m;
      tick;
      check(vt[i].name, vt[i].want);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0; mask = 8'h00;

    run_case("ff", 8'hFF, 1'b0, -1, 1000);
    run_case("a4", 8'hA4, 1'b0, -1, 1000);
    // Looping 0,7,0,7: abort while ch7 is in its third ON cycle (trace index 20) of the second pass.
    run_case("81loop", 8'h81, 1'b1, 21, 40);
    run_case("zero", 8'h00, 1'b0, -1, 1000);
    run_case("0f", 8'h0F, 1'b0, -1, 1000);

    // Reset asserted mid-ON on channel 3, then a fresh start with a new mask.
    start = 1'b1; mask = 8'h08; loop = 1'b1;
    tick;
    start = 1'b0;
    check("rst_mid_on0", mk(3, 1, 1, 0));
    tick;
    check("rst_mid_on1", mk(3, 1, 1, 0));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_cleared", 6'b0);
    tick;
    check("rst_mid_quiet", 6'b0);
    run_case("after_rst", 8'h30, 1'b0, -1, 1000);

    // Random sweeps, some looped (always aborted), some aborted partway.
    for (int n = 0; n < 25; n++) begin
      rm = 8'($urandom);
      rl = 1'($urandom);
      if (rl) begin
        len = $urandom_range(10, 60);
        ab  = $urandom_range(1, len - 1);
      end else begin
        len = $countones(rm) * (ON + OFF) + 1;
        ab  = (rm != 8'h00 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
      end
      run_case($sformatf("rnd%0d", n), rm, rl, ab, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
